// File: rtl/mseq_rx_checker.sv
// rtl/mseq_rx_checker.sv - M-sequence receive checker: self-seeding LFSR, lock/loss FSM
// Bit/error counters are built only when MSEQ_RX_ERR_CNT_EN is defined.
module mseq_rx_checker #(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] MSEQ_POLY   = DATA_WIDTH'(16'hB400),
  parameter int                    LOCK_THRESH = 64,
  parameter int                    LOSS_THRESH = 8,
  parameter int                    CNT_WIDTH   = 32
) (
  input  logic                 MSEQ_clk,
  input  logic                 MSEQ_rst,
  input  logic                 MSEQ_din,
  input  logic                 MSEQ_din_vld,
  output logic [1:0]           MSEQ_state,
  output logic                 MSEQ_locked,
  output logic                 MSEQ_bit_err,
  output logic [CNT_WIDTH-1:0] MSEQ_bit_cnt,
  output logic [CNT_WIDTH-1:0] MSEQ_err_cnt
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int LW = $clog2(DATA_WIDTH + 1);
  localparam int MW = $clog2(LOCK_THRESH + 1);
  localparam int XW = $clog2(LOSS_THRESH + 1);

  localparam logic [LW-1:0] LOAD_LAST  = LW'(DATA_WIDTH - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_THRESH - 1);
  localparam logic [XW-1:0] MISS_LAST  = XW'(LOSS_THRESH - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] s;
  logic [LW-1:0]         load_cnt;
  logic [MW-1:0]         match_cnt;
  logic [XW-1:0]         miss_cnt;

  logic                  pred;
  logic                  miss;
  logic [DATA_WIDTH-1:0] s_load;

  assign pred   = ^(s & MSEQ_POLY);
  assign miss   = MSEQ_din ^ pred;
  assign s_load = {s[DATA_WIDTH-2:0], MSEQ_din};

  assign MSEQ_state = state;

  always_ff @(posedge MSEQ_clk or posedge MSEQ_rst) begin
    if (MSEQ_rst) begin
      state        <= ST_LOAD;
      s            <= '0;
      load_cnt     <= '0;
      match_cnt    <= '0;
      miss_cnt     <= '0;
      MSEQ_locked  <= 1'b0;
      MSEQ_bit_err <= 1'b0;
    end else begin
      MSEQ_bit_err <= 1'b0;
      if (MSEQ_din_vld) begin
        case (state)
          ST_LOAD: begin
            s <= s_load;
            if (load_cnt == LOAD_LAST) begin
              // An all-zero seed would lock the LFSR at zero forever, so reload.
              load_cnt  <= '0;
              match_cnt <= '0;
              if (s_load != '0) state <= ST_CHECK;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
          ST_CHECK: begin
            s <= {s[DATA_WIDTH-2:0], pred};
            if (miss) begin
              MSEQ_bit_err <= 1'b1;
              state        <= ST_LOAD;
              load_cnt     <= '0;
              match_cnt    <= '0;
            end else if (match_cnt == MATCH_LAST) begin
              state       <= ST_LOCKED;
              MSEQ_locked <= 1'b1;
              match_cnt   <= '0;
              miss_cnt    <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            s <= {s[DATA_WIDTH-2:0], pred};
            if (miss) begin
              MSEQ_bit_err <= 1'b1;
              if (miss_cnt == MISS_LAST) begin
                state       <= ST_LOAD;
                MSEQ_locked <= 1'b0;
                load_cnt    <= '0;
                miss_cnt    <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            state       <= ST_LOAD;
            MSEQ_locked <= 1'b0;
            load_cnt    <= '0;
          end
        endcase
      end
    end
  end

`ifdef MSEQ_RX_ERR_CNT_EN
  logic count_beat;

  assign count_beat = MSEQ_din_vld && (state == ST_LOCKED);

  // Counters saturate and survive loss of lock; only reset clears them.
  always_ff @(posedge MSEQ_clk or posedge MSEQ_rst) begin
    if (MSEQ_rst) begin
      MSEQ_bit_cnt <= '0;
      MSEQ_err_cnt <= '0;
    end else if (count_beat) begin
      if (MSEQ_bit_cnt != '1) MSEQ_bit_cnt <= MSEQ_bit_cnt + 1'b1;
      if (miss && (MSEQ_err_cnt != '1)) MSEQ_err_cnt <= MSEQ_err_cnt + 1'b1;
    end
  end
`else
  assign MSEQ_bit_cnt = '0;
  assign MSEQ_err_cnt = '0;
`endif

endmodule

// File: tb/tb_mseq_rx_checker.sv
// tb/tb_mseq_rx_checker.sv - randomized bench with behavioural model for mseq_rx_checker
// Expected counter values follow MSEQ_RX_ERR_CNT_EN.
module tb_mseq_rx_checker;

  localparam int          W      = 16;
  localparam logic [15:0] POLY   = 16'hB400;
  localparam int          LOCK_T = 64;
  localparam int          LOSS_T = 8;
  localparam int          CW     = 8;
  localparam int          MAXC   = (1 << CW) - 1;
`ifdef MSEQ_RX_ERR_CNT_EN
  localparam int          CNT_ON = 1;
`else
  localparam int          CNT_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din = 1'b0;
  logic          vld = 1'b0;
  logic [1:0]    state;
  logic          locked;
  logic          bit_err;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  mseq_rx_checker #(
    .DATA_WIDTH (W),
    .MSEQ_POLY  (POLY),
    .LOCK_THRESH(LOCK_T),
    .LOSS_THRESH(LOSS_T),
    .CNT_WIDTH  (CW)
  ) dut (
    .MSEQ_clk    (clk),
    .MSEQ_rst    (rst),
    .MSEQ_din    (din),
    .MSEQ_din_vld(vld),
    .MSEQ_state  (state),
    .MSEQ_locked (locked),
    .MSEQ_bit_err(bit_err),
    .MSEQ_bit_cnt(bit_cnt),
    .MSEQ_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Model: hist[k] is the bit that entered the receiver window k beats ago.
  logic [15:0] poly_v = POLY;
  int hist [W];
  int m_mode  = 0;
  int m_load  = 0;
  int m_match = 0;
  int m_miss  = 0;
  int m_err   = 0;
  int m_bc    = 0;
  int m_ec    = 0;
  int mb, mp;

  function automatic int predict();
    int x = 0;
    for (int k = 0; k < W; k++) if (poly_v[k]) x ^= hist[k];
    return x;
  endfunction

  function automatic void push(input int b);
    for (int k = W - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = b;
  endfunction

  function automatic bit window_zero();
    for (int k = 0; k < W; k++) if (hist[k] != 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < W; k++) hist[k] = 0;
      m_mode = 0; m_load = 0; m_match = 0; m_miss = 0;
      m_err = 0; m_bc = 0; m_ec = 0;
    end else begin
      m_err = 0;
      if (vld) begin
        mb = int'(din);
        case (m_mode)
          0: begin
            push(mb);
            m_load++;
            if (m_load == W) begin
              m_load = 0;
              if (!window_zero()) begin m_mode = 1; m_match = 0; end
            end
          end
          1: begin
            mp = predict();
            push(mp);
            if (mb == mp) begin
              m_match++;
              if (m_match == LOCK_T) begin m_mode = 2; m_miss = 0; end
            end else begin
              m_err = 1; m_mode = 0; m_load = 0; m_match = 0;
            end
          end
          default: begin
            mp = predict();
            push(mp);
            if (m_bc < MAXC) m_bc++;
            if (mb != mp) begin
              m_err = 1;
              if (m_ec < MAXC) m_ec++;
              m_miss++;
              if (m_miss == LOSS_T) begin m_mode = 0; m_load = 0; m_miss = 0; end
            end else begin
              m_miss = 0;
            end
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (state !== 2'(m_mode) || locked !== 1'(m_mode == 2) || bit_err !== 1'(m_err) ||
        bit_cnt !== CW'(m_bc * CNT_ON) || err_cnt !== CW'(m_ec * CNT_ON)) begin
      failures++;
      $display("FAIL cycle_compare t=%0t actual state=%0d locked=%b bit_err=%b bit_cnt=%0d err_cnt=%0d required state=%0d locked=%0d bit_err=%0d bit_cnt=%0d err_cnt=%0d",
               $time, state, locked, bit_err, bit_cnt, err_cnt,
               m_mode, (m_mode == 2), m_err, m_bc * CNT_ON, m_ec * CNT_ON);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  logic [15:0] gen_s;

  task automatic gen_bit(output logic b);
    b = ^(gen_s & POLY);
    gen_s = {gen_s[14:0], b};
  endtask

  task automatic beat(input logic b, input logic v);
    din = b;
    vld = v;
    @(posedge clk);
    #1;
  endtask

  logic b;
  int   first_chk, first_lock, burst;

  initial begin
    gen_s = 16'h0001;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", int'(state), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_bit_cnt", int'(bit_cnt), 0);
    check("reset_err_cnt", int'(err_cnt), 0);
    rst = 1'b0;

    // Clean lock from seed 1
    first_chk = 0; first_lock = 0;
    for (int i = 1; i <= 100; i++) begin
      gen_bit(b);
      beat(b, 1'b1);
      if (state == 2'd1 && first_chk == 0) first_chk = i;
      if (locked && first_lock == 0) first_lock = i;
    end
    check("clean_check_beat", first_chk, 16);
    check("clean_lock_beat", first_lock, 80);
    check("clean_err_cnt", int'(err_cnt), 0);
    check("clean_bit_cnt", int'(bit_cnt), CNT_ON * 20);

    // Single flipped bit while locked
    gen_bit(b);
    beat(~b, 1'b1);
    check("single_bit_err", int'(bit_err), 1);
    check("single_locked", int'(locked), 1);
    check("single_err_cnt", int'(err_cnt), CNT_ON);
    gen_bit(b);
    beat(b, 1'b1);
    check("single_err_clears", int'(bit_err), 0);
    for (int i = 0; i < 5; i++) begin gen_bit(b); beat(b, 1'b1); end

    // Loss after 8 consecutive inverted bits
    for (int i = 1; i <= 8; i++) begin
      gen_bit(b);
      beat(~b, 1'b1);
      if (i == 7) check("loss_still_locked", int'(state), 2);
    end
    check("loss_state", int'(state), 0);
    check("loss_err_cnt_hold", int'(err_cnt), CNT_ON * 9);
    check("loss_bit_cnt_hold", int'(bit_cnt), CNT_ON * 35);

    first_lock = 0;
    for (int i = 1; i <= 100; i++) begin
      gen_bit(b);
      beat(b, 1'b1);
      if (locked && first_lock == 0) first_lock = i;
    end
    check("relock_beat", first_lock, 80);
    check("relock_err_cnt", int'(err_cnt), CNT_ON * 9);
    check("relock_bit_cnt", int'(bit_cnt), CNT_ON * 55);

    // Asynchronous reset mid-lock, sampled before any further clock edge
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_state", int'(state), 0);
    check("async_locked", int'(locked), 0);
    check("async_bit_err", int'(bit_err), 0);
    check("async_bit_cnt", int'(bit_cnt), 0);
    check("async_err_cnt", int'(err_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // CHECK failure after 30 matches, then an all-zero load
    gen_s = 16'h0001;
    for (int i = 0; i < 46; i++) begin gen_bit(b); beat(b, 1'b1); end
    check("chk_before_fail", int'(state), 1);
    gen_bit(b);
    beat(~b, 1'b1);
    check("chk_fail_state", int'(state), 0);
    check("chk_fail_bit_err", int'(bit_err), 1);
    for (int i = 0; i < 16; i++) beat(1'b0, 1'b1);
    check("zero_load_state", int'(state), 0);
    for (int i = 0; i < 16; i++) begin gen_bit(b); beat(b, 1'b1); end
    check("reload_check_state", int'(state), 1);

    // Gapped valid: beats only on odd clocks
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    gen_s = 16'h0001;
    first_lock = 0;
    for (int i = 1; i <= 400 && first_lock == 0; i++) begin
      if (i % 2 == 1) begin
        gen_bit(b);
        beat(b, 1'b1);
      end else begin
        beat(1'($urandom_range(1, 0)), 1'b0);
      end
      if (locked) first_lock = i;
    end
    check("gapped_lock_clocks", first_lock, 159);
    check("gapped_bit_cnt", int'(bit_cnt), 0);

    // Randomized traffic: gaps, single flips, inversion bursts, one reset
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    gen_s = 16'($urandom_range(65535, 1));
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1800) begin
        rst = 1'b1;
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        rst = 1'b0;
      end
      if ($urandom_range(9, 0) < 7) begin
        gen_bit(b);
        if (burst == 0 && $urandom_range(299, 0) == 0) burst = $urandom_range(10, 5);
        if (burst > 0) begin
          b = ~b;
          burst--;
        end else if ($urandom_range(149, 0) == 0) begin
          b = ~b;
        end
        beat(b, 1'b1);
      end else begin
        beat(1'($urandom_range(1, 0)), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
